// File: rtl/vend_service_arbiter.sv
// vend_service_arbiter: round-robin sharing of one dispense motor and one change hopper
// between N_REQ front-ends, sequencing motor, value-2 coin, value-1 coin, then done.
module vend_service_arbiter #(
    parameter int N_REQ        = 4,
    parameter int MOTOR_CYCLES = 8,
    parameter int COIN_GAP     = 3
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] want_item,
    input  logic [N_REQ-1:0] want_chg1,
    input  logic [N_REQ-1:0] want_chg2,
    input  logic             hopper_ready,
    output logic [N_REQ-1:0] grant,
    output logic [N_REQ-1:0] done,
    output logic             motor_on,
    output logic             coin1_pulse,
    output logic             coin2_pulse,
    output logic             busy
);
    localparam int PW   = $clog2(N_REQ);
    localparam int CMAX = MOTOR_CYCLES > COIN_GAP ? MOTOR_CYCLES : COIN_GAP;
    localparam int CW   = $clog2(CMAX + 1);
    localparam logic [N_REQ-1:0] ONE = N_REQ'(1);

    typedef enum logic [2:0] {IDLE, MOTOR, C2, C1, GAP, DONE} state_t;

    state_t           state, state_nx;
    logic [PW-1:0]    ptr, gidx, sel;
    logic [PW:0]      scan;
    logic [CW-1:0]    cnt;
    logic             chg1_p, chg2_p, found, start;
    logic [N_REQ-1:0] grant_nx, done_nx;
    logic             motor_nx, coin1_nx, coin2_nx;

    // Lowest offset from the pointer wins, so scan downward and let later hits overwrite.
    always_comb begin
        found = 1'b0;
        sel   = ptr;
        scan  = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            scan = {1'b0, ptr} + (PW + 1)'(k);
            scan = scan >= (PW + 1)'(N_REQ) ? scan - (PW + 1)'(N_REQ) : scan;
            if (req[scan[PW-1:0]]) begin
                found = 1'b1;
                sel   = scan[PW-1:0];
            end
        end
    end

    // The done cycle still holds the old req high, so IDLE waits until done has dropped.
    assign start = (state == IDLE) && !(|done) && found;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            ptr         <= '0;
            gidx        <= '0;
            cnt         <= '0;
            chg1_p      <= 1'b0;
            chg2_p      <= 1'b0;
            grant       <= '0;
            done        <= '0;
            motor_on    <= 1'b0;
            coin1_pulse <= 1'b0;
            coin2_pulse <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_nx;
            grant       <= grant_nx;
            done        <= done_nx;
            motor_on    <= motor_nx;
            coin1_pulse <= coin1_nx;
            coin2_pulse <= coin2_nx;
            busy        <= |grant_nx;
            if (start) begin
                gidx   <= sel;
                chg2_p <= want_chg2[sel];
                chg1_p <= want_chg1[sel];
            end else if (state == C2 && hopper_ready) begin
                chg2_p <= 1'b0;
            end else if (state == C1 && hopper_ready) begin
                chg1_p <= 1'b0;
            end
            if (start)
                cnt <= CW'(MOTOR_CYCLES);
            else if ((state == C2 || state == C1) && hopper_ready)
                cnt <= CW'(COIN_GAP);
            else if (cnt != '0)
                cnt <= cnt - 1'b1;
            if (state == DONE)
                ptr <= gidx == PW'(N_REQ - 1) ? '0 : gidx + 1'b1;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = want_item[sel] ? MOTOR : want_chg2[sel] ? C2 : want_chg1[sel] ? C1 : DONE;
            MOTOR:   if (cnt == CW'(1)) state_nx = chg2_p ? C2 : chg1_p ? C1 : DONE;
            C2, C1:  if (hopper_ready) state_nx = GAP;
            GAP:     if (cnt == CW'(1)) state_nx = chg1_p ? C1 : DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Outputs are registered from the current state, so each lags its state by one cycle.
    always_comb begin
        grant_nx = state != IDLE ? grant : start ? ONE << sel : '0;
        done_nx  = state == DONE ? grant : '0;
        motor_nx = state == MOTOR;
        coin2_nx = state == C2 && hopper_ready;
        coin1_nx = state == C1 && hopper_ready;
    end
endmodule

// File: tb/tb_vend_service_arbiter.sv
// tb_vend_service_arbiter: scoreboard bench; expected service records are queued with the
// stimulus and compared against records the monitor builds from the DUT outputs.
module tb_vend_service_arbiter;
    localparam int N = 4;
    localparam int M = 8;
    localparam int G = 3;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic [N-1:0] req = '0, want_item = '0, want_chg1 = '0, want_chg2 = '0;
    logic         hopper_ready = 1'b1;
    logic [N-1:0] grant, done;
    logic         motor_on, coin1_pulse, coin2_pulse, busy;

    always #5 clock = ~clock;

    vend_service_arbiter #(.N_REQ(N), .MOTOR_CYCLES(M), .COIN_GAP(G)) dut (
        .clock(clock), .reset(reset), .req(req), .want_item(want_item),
        .want_chg1(want_chg1), .want_chg2(want_chg2), .hopper_ready(hopper_ready),
        .grant(grant), .done(done), .motor_on(motor_on), .coin1_pulse(coin1_pulse),
        .coin2_pulse(coin2_pulse), .busy(busy)
    );

    typedef struct packed {
        logic [3:0] idx;
        logic [3:0] done_vec;
        logic [7:0] done_off, motor_cnt, motor_last, c2_off, c1_off, c2_cnt, c1_cnt, bad, gap;
    } svc_t;

    svc_t         obs_q[$];
    svc_t         exp_q[$];
    int           compared = 0, mismatched = 0, rd = 0;
    logic [N-1:0] hold = '0;

    int   cyc = 0, t0 = 0, fall = 0;
    bit   active = 0, have_fall = 0;
    svc_t cur = '0;

    // Monitor: one record per service, offsets counted from the first grant cycle.
    always @(negedge clock) begin
        cyc++;
        if (!reset) begin
            active = 0;
            have_fall = 0;
        end else begin
            if (grant != '0 && !active) begin
                active = 1;
                t0 = cyc;
                cur = '0;
                cur.c2_off = 8'hFF;
                cur.c1_off = 8'hFF;
                cur.done_off = 8'hFF;
                for (int i = 0; i < N; i++) if (grant[i]) cur.idx = 4'(i);
                cur.gap = have_fall ? 8'(cyc - fall) : 8'hFF;
            end
            if (active) begin
                if (grant == '0) begin
                    active = 0;
                    have_fall = 1;
                    fall = cyc;
                end else begin
                    if (!$onehot(grant) || (int'(motor_on) + int'(coin1_pulse) + int'(coin2_pulse)) > 1)
                        cur.bad = cur.bad + 8'd1;
                    if (motor_on) begin
                        cur.motor_cnt = cur.motor_cnt + 8'd1;
                        cur.motor_last = 8'(cyc - t0);
                    end
                    if (coin2_pulse) begin
                        cur.c2_cnt = cur.c2_cnt + 8'd1;
                        cur.c2_off = 8'(cyc - t0);
                    end
                    if (coin1_pulse) begin
                        cur.c1_cnt = cur.c1_cnt + 8'd1;
                        cur.c1_off = 8'(cyc - t0);
                    end
                    if (done != '0) begin
                        cur.done_vec = done;
                        cur.done_off = 8'(cyc - t0);
                        obs_q.push_back(cur);
                    end
                end
            end
        end
    end

    function automatic svc_t mk(int idx, int it, int c2, int c1, int stall);
        svc_t e;
        int   m;
        m = it * M;
        e = '0;
        e.idx = 4'(idx);
        e.done_vec = 4'(1 << idx);
        e.motor_cnt = 8'(m);
        e.motor_last = 8'(m);
        e.c2_off = c2 != 0 ? 8'(1 + m) : 8'hFF;
        e.c1_off = c1 != 0 ? 8'(1 + m + c2 * (1 + G) + stall) : 8'hFF;
        e.c2_cnt = 8'(c2);
        e.c1_cnt = 8'(c1);
        e.done_off = 8'(1 + m + (1 + G) * (c2 + c1) + stall);
        return e;
    endfunction

    // Front-ends drop req on their own done unless held; waits for n more records.
    task automatic wait_svc(input int n, output bit ok);
        ok = 0;
        for (int i = 0; i < 400 && !ok; i++) begin
            @(negedge clock);
            #1;
            req = req & ~(done & ~hold);
            ok = obs_q.size() >= rd + n;
        end
    endtask

    task automatic test_reset();
        int b;
        reset = 1'b0;
        repeat (3) @(negedge clock);
        compared++;
        if ({grant, done, motor_on, coin1_pulse, coin2_pulse, busy} !== '0) begin
            mismatched++;
            $display("FAIL reset_outputs: got %b required 0", {grant, done, motor_on, coin1_pulse, coin2_pulse, busy});
        end
        reset = 1'b1;
        b = 0;
        repeat (20) begin
            @(negedge clock);
            if (busy) b++;
        end
        compared++;
        if (b != 0) begin
            mismatched++;
            $display("FAIL idle_busy: busy high %0d cycles, required 0", b);
        end
    endtask

    task automatic test_single_item();
        bit   ok;
        svc_t o, e;
        want_item = 4'b0001; want_chg2 = '0; want_chg1 = '0;
        exp_q.push_back(mk(0, 1, 0, 0, 0));
        req = 4'b0001;
        @(negedge clock);
        compared++;
        if (grant !== 4'b0001) begin
            mismatched++;
            $display("FAIL grant_latency: got %b required 0001", grant);
        end
        wait_svc(1, ok);
        compared++;
        if (!ok) begin
            mismatched++;
            $display("FAIL single_timeout: got %0d services required 1", obs_q.size() - rd);
            exp_q.delete(); rd = obs_q.size();
        end else while (exp_q.size() > 0) begin
            o = obs_q[rd]; rd++; o.gap = '0; e = exp_q.pop_front();
            compared++;
            if (o !== e) begin mismatched++; $display("FAIL single_svc: got %p required %p", o, e); end
        end
        repeat (3) @(negedge clock);
    endtask

    task automatic test_item_coins();
        bit   ok;
        svc_t o, e;
        want_item = 4'b0100; want_chg2 = 4'b0100; want_chg1 = 4'b0100;
        exp_q.push_back(mk(2, 1, 1, 1, 0));
        req = 4'b0100;
        wait_svc(1, ok);
        compared++;
        if (!ok) begin
            mismatched++;
            $display("FAIL coins_timeout: got %0d services required 1", obs_q.size() - rd);
            exp_q.delete(); rd = obs_q.size();
        end else while (exp_q.size() > 0) begin
            o = obs_q[rd]; rd++; o.gap = '0; e = exp_q.pop_front();
            compared++;
            if (o !== e) begin mismatched++; $display("FAIL coins_svc: got %p required %p", o, e); end
        end
        repeat (3) @(negedge clock);
    endtask

    task automatic test_round_robin();
        bit          ok;
        svc_t        o, e;
        logic [7:0]  g;
        reset = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        want_item = 4'b0010; want_chg2 = 4'b1100; want_chg1 = 4'b1000;
        exp_q.push_back(mk(0, 0, 0, 0, 0));
        exp_q.push_back(mk(1, 1, 0, 0, 0));
        exp_q.push_back(mk(2, 0, 1, 0, 0));
        exp_q.push_back(mk(3, 0, 1, 1, 0));
        exp_q.push_back(mk(0, 0, 0, 0, 0));
        hold = 4'b1111;
        req = 4'b1111;
        wait_svc(5, ok);
        req = '0;
        hold = '0;
        compared++;
        if (!ok) begin
            mismatched++;
            $display("FAIL rr_timeout: got %0d services required 5", obs_q.size() - rd);
            exp_q.delete(); rd = obs_q.size();
        end else for (int k = 0; exp_q.size() > 0; k++) begin
            o = obs_q[rd]; rd++; g = o.gap; o.gap = '0; e = exp_q.pop_front();
            compared++;
            if (o !== e) begin mismatched++; $display("FAIL rr_svc%0d: got %p required %p", k, o, e); end
            if (k > 0) begin
                compared++;
                if (g !== 8'd1) begin mismatched++; $display("FAIL rr_idle_gap%0d: got %0d required 1", k, g); end
            end
        end
        repeat (3) @(negedge clock);
    endtask

    task automatic test_hopper_stall();
        bit   ok;
        svc_t o, e;
        want_item = '0; want_chg2 = '0; want_chg1 = 4'b0100;
        hopper_ready = 1'b0;
        exp_q.push_back(mk(2, 0, 0, 1, 5));
        req = 4'b0100;
        for (int i = 0; i < 50 && grant == '0; i++) @(negedge clock);
        repeat (5) @(posedge clock);
        @(negedge clock);
        hopper_ready = 1'b1;
        wait_svc(1, ok);
        compared++;
        if (!ok) begin
            mismatched++;
            $display("FAIL stall_timeout: got %0d services required 1", obs_q.size() - rd);
            exp_q.delete(); rd = obs_q.size();
        end else while (exp_q.size() > 0) begin
            o = obs_q[rd]; rd++; o.gap = '0; e = exp_q.pop_front();
            compared++;
            if (o !== e) begin mismatched++; $display("FAIL stall_svc: got %p required %p", o, e); end
        end
        repeat (3) @(negedge clock);
    endtask

    task automatic test_abort();
        bit   ok;
        svc_t o, e;
        int   mc;
        want_item = 4'b1000; want_chg2 = 4'b0010; want_chg1 = '0;
        req = 4'b1000;
        mc = 0;
        for (int i = 0; i < 50 && mc < 4; i++) begin
            @(negedge clock);
            if (motor_on) mc++;
        end
        req = 4'b1010;
        #2 reset = 1'b0;
        #1;
        compared++;
        if ({motor_on, coin1_pulse, coin2_pulse, grant, done, busy} !== '0 || mc != 4) begin
            mismatched++;
            $display("FAIL abort_async: outputs %b motor cycles %0d, required 0 and 4",
                     {motor_on, coin1_pulse, coin2_pulse, grant, done, busy}, mc);
        end
        repeat (2) @(negedge clock);
        compared++;
        if (obs_q.size() != rd) begin
            mismatched++;
            $display("FAIL abort_no_done: got %0d done records required 0", obs_q.size() - rd);
            rd = obs_q.size();
        end
        reset = 1'b1;
        exp_q.push_back(mk(1, 0, 1, 0, 0));
        exp_q.push_back(mk(3, 1, 0, 0, 0));
        wait_svc(2, ok);
        compared++;
        if (!ok) begin
            mismatched++;
            $display("FAIL abort_timeout: got %0d services required 2", obs_q.size() - rd);
            exp_q.delete(); rd = obs_q.size();
        end else while (exp_q.size() > 0) begin
            o = obs_q[rd]; rd++; o.gap = '0; e = exp_q.pop_front();
            compared++;
            if (o !== e) begin mismatched++; $display("FAIL abort_svc: got %p required %p", o, e); end
        end
        repeat (3) @(negedge clock);
    endtask

    task automatic test_latch_and_empty();
        bit   ok;
        svc_t o, e;
        want_item = '0; want_chg2 = 4'b0001; want_chg1 = '0;
        exp_q.push_back(mk(0, 0, 1, 0, 0));
        req = 4'b0001;
        @(negedge clock);
        req = '0;
        want_item = 4'b1111; want_chg1 = 4'b1111; want_chg2 = '0;
        wait_svc(1, ok);
        repeat (3) @(negedge clock);
        want_item = '0; want_chg1 = '0; want_chg2 = '0;
        exp_q.push_back(mk(1, 0, 0, 0, 0));
        req = 4'b0010;
        if (ok) wait_svc(2, ok);
        compared++;
        if (!ok) begin
            mismatched++;
            $display("FAIL latch_empty_timeout: got %0d services required 2", obs_q.size() - rd);
            exp_q.delete(); rd = obs_q.size();
        end else while (exp_q.size() > 0) begin
            o = obs_q[rd]; rd++; o.gap = '0; e = exp_q.pop_front();
            compared++;
            if (o !== e) begin mismatched++; $display("FAIL latch_empty_svc: got %p required %p", o, e); end
        end
        repeat (3) @(negedge clock);
    endtask

    initial begin
        test_reset();
        test_single_item();
        test_item_coins();
        test_round_robin();
        test_hopper_stall();
        test_abort();
        test_latch_and_empty();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
